// File: rtl/branch_resolver_pkg.sv
// Shared constants and types for the branch resolver: branch condition codes,
// flush FSM states and the link offset.
package branch_resolver_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam int LINK_OFFSET = 4;
    // Counter width covers the full FLUSH_CYCLES range of 1..15.
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/branch_resolver_cond.sv
// Combinational evaluation of the branch condition from the compare flags of A - B.
// The reserved codes 010/011 never evaluate true and raise illegal.
module branch_cond
    import branch_resolver_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       Zflag,
    input  logic       Cflag,
    input  logic       Vflag,
    input  logic       Sflag,
    output logic       cond,
    output logic       illegal
);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:     cond = Zflag;
            BNE:     cond = !Zflag;
            BLT:     cond = (Sflag != Vflag);
            BGE:     cond = (Sflag == Vflag);
            BLTU:    cond = !Cflag;
            BGEU:    cond = Cflag;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves branch/JAL/JALR outcome, registers target and link, and holds off
// new requests for FLUSH_CYCLES cycles after a taken redirect.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int n            = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         is_branch,
    input  logic         is_jal,
    input  logic         is_jalr,
    input  logic [2:0]   funct3,
    input  logic [n-1:0] pc,
    input  logic [n-1:0] imm,
    input  logic [n-1:0] rs1,
    input  logic         Zflag,
    input  logic         Cflag,
    input  logic         Vflag,
    input  logic         Sflag,
    output logic         out_valid,
    output logic         taken,
    output logic [n-1:0] target,
    output logic [n-1:0] link,
    output logic         illegal,
    output logic         misalign,
    output logic         flush
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // the producer holds it otherwise. Results leave as a one-cycle out_valid
    // pulse with no backpressure.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic         out_valid_q, taken_q, illegal_q, misalign_q;
    logic [n-1:0] target_q, link_q;

    logic         cond, f3_illegal;
    logic         accept, raw_taken, taken_d, misalign_d, illegal_d;
    logic [n-1:0] target_d, link_d;

    branch_cond u_cond (
        .funct3  (funct3),
        .Zflag   (Zflag),
        .Cflag   (Cflag),
        .Vflag   (Vflag),
        .Sflag   (Sflag),
        .cond    (cond),
        .illegal (f3_illegal)
    );

    assign accept     = in_valid && (state_q == IDLE);
    assign target_d   = is_jalr ? ((rs1 + imm) & {{(n-1){1'b1}}, 1'b0}) : (pc + imm);
    assign link_d     = pc + n'(LINK_OFFSET);
    assign raw_taken  = is_jal || is_jalr || (is_branch && cond);
    assign misalign_d = raw_taken && target_d[1];
    assign taken_d    = raw_taken && !target_d[1];
    assign illegal_d  = is_branch && f3_illegal;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && taken_d) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            misalign_q  <= 1'b0;
            target_q    <= '0;
            link_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= accept;
            taken_q     <= accept && taken_d;
            illegal_q   <= accept && illegal_d;
            misalign_q  <= accept && misalign_d;
            if (accept) begin
                target_q <= target_d;
                link_q   <= link_d;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign flush     = (state_q == FLUSH);
    assign out_valid = out_valid_q;
    assign taken     = taken_q;
    assign illegal   = illegal_q;
    assign misalign  = misalign_q;
    assign target    = target_q;
    assign link      = link_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: instance a uses FLUSH_CYCLES = 2, instance b
// uses FLUSH_CYCLES = 3 with its own reset for the mid-flush reset case.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] pc = '0, imm = '0, rs1 = '0;
    logic        zf = 1'b0, cf = 1'b0, vf = 1'b0, sf = 1'b0;

    logic        a_ready, a_valid, a_taken, a_illegal, a_misalign, a_flush;
    logic [31:0] a_target, a_link;
    logic        b_ready, b_valid, b_taken, b_illegal, b_misalign, b_flush;
    logic [31:0] b_target, b_link;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_resolver #(.n(32), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
        .pc(pc), .imm(imm), .rs1(rs1),
        .Zflag(zf), .Cflag(cf), .Vflag(vf), .Sflag(sf),
        .out_valid(a_valid), .taken(a_taken), .target(a_target), .link(a_link),
        .illegal(a_illegal), .misalign(a_misalign), .flush(a_flush)
    );

    branch_resolver #(.n(32), .FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid), .in_ready(b_ready),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
        .pc(pc), .imm(imm), .rs1(rs1),
        .Zflag(zf), .Cflag(cf), .Vflag(vf), .Sflag(sf),
        .out_valid(b_valid), .taken(b_taken), .target(b_target), .link(b_link),
        .illegal(b_illegal), .misalign(b_misalign), .flush(b_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic br, input logic jl, input logic jr, input logic [2:0] f3,
                       input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                       input logic z, input logic c, input logic v, input logic s);
        is_branch = br; is_jal = jl; is_jalr = jr; funct3 = f3;
        pc = p; imm = im; rs1 = r1;
        zf = z; cf = c; vf = v; sf = s;
        in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a taken request pending: nothing may be accepted.
        req(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 1, 0, 0, 0);
        tick(); tick();
        chk("rst_in_ready", 32'(a_ready), 32'd1);
        chk("rst_out_valid", 32'(a_valid), 32'd0);
        chk("rst_taken", 32'(a_taken), 32'd0);
        chk("rst_flush", 32'(a_flush), 32'd0);
        chk("rst_illegal", 32'(a_illegal), 32'd0);
        chk("rst_misalign", 32'(a_misalign), 32'd0);
        chk("rst_target", a_target, 32'h0);
        chk("rst_link", a_link, 32'h0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        tick();
        chk("post_rst_no_accept", 32'(a_valid), 32'd0);

        // BEQ taken, FLUSH_CYCLES = 2.
        req(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 1, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("beq_valid", 32'(a_valid), 32'd1);
        chk("beq_taken", 32'(a_taken), 32'd1);
        chk("beq_target", a_target, 32'h120);
        chk("beq_link", a_link, 32'h104);
        chk("beq_flush1", 32'(a_flush), 32'd1);
        chk("beq_ready1", 32'(a_ready), 32'd0);
        tick();
        chk("beq_valid_pulse", 32'(a_valid), 32'd0);
        chk("beq_flush2", 32'(a_flush), 32'd1);
        chk("beq_ready2", 32'(a_ready), 32'd0);
        chk("beq_target_hold", a_target, 32'h120);
        tick();
        chk("beq_flush_end", 32'(a_flush), 32'd0);
        chk("beq_ready_back", 32'(a_ready), 32'd1);
        tick(); tick();

        // BLTU back-to-back: C = 1 (not taken) then C = 0 (taken).
        req(1, 0, 0, 3'b110, 32'h200, 32'h40, 32'h0, 0, 1, 0, 0);
        tick();
        chk("bltu1_valid", 32'(a_valid), 32'd1);
        chk("bltu1_taken", 32'(a_taken), 32'd0);
        chk("bltu1_ready", 32'(a_ready), 32'd1);
        chk("bltu1_flush", 32'(a_flush), 32'd0);
        cf = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("bltu2_valid", 32'(a_valid), 32'd1);
        chk("bltu2_taken", 32'(a_taken), 32'd1);
        chk("bltu2_target", a_target, 32'h240);
        chk("bltu2_flush", 32'(a_flush), 32'd1);
        tick(); tick(); tick(); tick();

        // JALR misaligned, then aligned.
        req(0, 0, 1, 3'b011, 32'h300, 32'h0, 32'h1003, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("jalr_mis_target", a_target, 32'h1002);
        chk("jalr_mis_misalign", 32'(a_misalign), 32'd1);
        chk("jalr_mis_taken", 32'(a_taken), 32'd0);
        chk("jalr_mis_flush", 32'(a_flush), 32'd0);
        chk("jalr_mis_ready", 32'(a_ready), 32'd1);
        chk("jalr_mis_illegal", 32'(a_illegal), 32'd0);
        tick(); tick(); tick();
        req(0, 0, 1, 3'b000, 32'h300, 32'h0, 32'h1001, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("jalr_ok_target", a_target, 32'h1000);
        chk("jalr_ok_taken", 32'(a_taken), 32'd1);
        chk("jalr_ok_misalign", 32'(a_misalign), 32'd0);
        chk("jalr_ok_link", a_link, 32'h304);
        tick(); tick(); tick(); tick();

        // Illegal funct3, BLT and BGE with S = V = 1.
        req(1, 0, 0, 3'b010, 32'h400, 32'h8, 32'h0, 1, 1, 1, 1);
        tick();
        in_valid = 1'b0;
        chk("ill_illegal", 32'(a_illegal), 32'd1);
        chk("ill_taken", 32'(a_taken), 32'd0);
        tick();
        req(1, 0, 0, 3'b100, 32'h400, 32'h8, 32'h0, 0, 0, 1, 1);
        tick();
        in_valid = 1'b0;
        chk("blt_taken", 32'(a_taken), 32'd0);
        chk("blt_illegal", 32'(a_illegal), 32'd0);
        tick();
        req(1, 0, 0, 3'b101, 32'h400, 32'h8, 32'h0, 0, 0, 1, 1);
        tick();
        in_valid = 1'b0;
        chk("bge_taken", 32'(a_taken), 32'd1);
        chk("bge_target", a_target, 32'h408);
        tick(); tick(); tick(); tick();

        // FLUSH_CYCLES = 3 instance: reset in the second flush cycle.
        req(1, 0, 0, 3'b001, 32'h500, 32'h10, 32'h0, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("b_taken", 32'(b_taken), 32'd1);
        chk("b_flush1", 32'(b_flush), 32'd1);
        tick();
        chk("b_flush2", 32'(b_flush), 32'd1);
        rst_n_b = 1'b0;
        #1;
        chk("b_rst_flush", 32'(b_flush), 32'd0);
        chk("b_rst_ready", 32'(b_ready), 32'd1);
        rst_n_b = 1'b1;
        req(1, 0, 0, 3'b001, 32'h600, 32'h4, 32'h0, 1, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("b_reaccept_valid", 32'(b_valid), 32'd1);
        chk("b_reaccept_taken", 32'(b_taken), 32'd0);
        chk("b_reaccept_link", b_link, 32'h604);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Consumes the Z/C/V/S flags produced by the ALU for a compare (A − B) together with the decoded branch/jump fields, and decides whether the instruction is taken. It computes and registers the redirect target and link address, then runs a flush sequencer that holds off new requests while the front end is squashed. It sits between the execute stage (ALU flag outputs) and the fetch/PC logic.

## Interface
- n, 32, datapath width for PC, immediate, rs1, target and link.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken redirect; legal range 1–15.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  resolver can accept; high only in IDLE.
- is_branch, is_jal, is_jalr  in  1 each  one-hot instruction class; all low means no control-flow effect.
- funct3  in  3  branch condition code.
- pc, imm, rs1  in  n  instruction PC, sign-extended immediate, rs1 value.
- Zflag, Cflag, Vflag, Sflag  in  1 each  flags of A − B.
- out_valid  out  1  one-cycle pulse per accepted request.
- taken  out  1  redirect required; qualified by out_valid.
- target  out  n  redirect address.
- link  out  n  pc + 4, for JAL/JALR writeback.
- illegal  out  1  funct3 010/011 with is_branch; qualified by out_valid.
- misalign  out  1  taken target with target[1] = 1; qualified by out_valid.
- flush  out  1  squash younger instructions.

## Operation
- Accept on rising clk when in_valid && in_ready; all inputs are sampled at that edge.
- Flag convention: C = 1 iff A ≥ B unsigned; S = sign of the result; V = signed overflow.
- Conditions by funct3:
  - 000 BEQ: Z.
  - 001 BNE: !Z.
  - 100 BLT: S ≠ V.
  - 101 BGE: S = V.
  - 110 BLTU: !C.
  - 111 BGEU: C.
  - 010/011: not taken, illegal = 1.
- Condition result is raw_taken.
- is_jal and is_jalr set raw_taken = 1 unconditionally; funct3 is ignored.
- Target arithmetic, modulo 2^n with no overflow detection:
  - branch/JAL: pc + imm.
  - JALR: (rs1 + imm) & ~1.
- link = pc + 4, modulo 2^n.
- misalign = raw_taken && target[1]. When misalign = 1, taken = 0 and no flush occurs; the trap logic consumes misalign.
- taken = raw_taken && !misalign.
- FSM states: IDLE, FLUSH.
  - IDLE → FLUSH on an accepted request with taken = 1; the flush counter loads FLUSH_CYCLES − 1.
  - FLUSH decrements the counter each cycle and returns to IDLE when the counter is 0.
  - Not-taken, illegal and misaligned requests stay in IDLE.
- in_valid during FLUSH is ignored (in_ready = 0); the upstream stage holds the request.
- Reset mid-FLUSH: abort immediately to IDLE with the counter cleared.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid, taken, illegal, misalign, flush = 0.
  - target, link = 0.
  - state = IDLE; counter = 0.
- Latency: a request accepted at edge t drives out_valid/taken/target/link/illegal/misalign from edge t until edge t+1 (one-cycle pulse). All outputs are registered.
- Taken request:
  - flush is high for exactly FLUSH_CYCLES cycles, starting in the same cycle as out_valid.
  - in_ready is low for the same cycles and returns high at edge t+FLUSH_CYCLES.
- Not taken: in_ready stays high, so back-to-back accepts every cycle are allowed.
- target/link hold their last value when out_valid = 0.
- No output backpressure; the consumer must accept every out_valid pulse.

## Structure
- A shared package holds:
  - funct3 constants BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - FSM state typedef {IDLE, FLUSH}.
  - Link offset constant 4.
- One combinational sub-module, branch_cond: inputs funct3 and the four flags; outputs cond and illegal.
- Target/link adders, output registers, FSM and counter live in branch_resolver.

## Test plan
- Reset with in_valid high → in_ready = 1, every output 0; no accept until rst_n rises.
- BEQ, Z = 1, pc = 0x100, imm = 0x20 → next cycle out_valid = 1, taken = 1, target = 0x120, link = 0x104; flush high 2 cycles; in_ready low 2 cycles.
- BLTU back-to-back on consecutive cycles, C = 1 then C = 0 → first result taken = 0 with in_ready staying high; second result taken = 1, then flush.
- JALR, rs1 = 0x1003, imm = 0 → target = 0x1002, misalign = 1, taken = 0, no flush. Repeat with rs1 = 0x1001 → target = 0x1000, taken = 1.
- funct3 = 010 with is_branch → illegal = 1, taken = 0. BLT with S = 1, V = 1 → taken = 0. BGE with S = 1, V = 1 → taken = 1.
- Taken branch with FLUSH_CYCLES = 3, rst_n pulsed low in the second flush cycle → flush = 0 and in_ready = 1 immediately. After release, a new request is accepted on the first edge.
